uart_tx_arbiter: RTL and testbench

//  Shares one UART byte transmitter among NREQ requesters (e.g. status reporter, rx echo, debug dump).

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rr_arbiter_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, defaults and one-hot helper for the uart tx arbiter
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_LOAD = 2'd2,
    ST_WAIT = 2'd3
  } arb_state_e;

  localparam int UART_DW      = 8;
  localparam int UART_TIMEOUT = 4096;
  localparam int UART_TOW     = 13;

  // Mask with only bit idx set; callers size-cast it down to their vector width.
  function automatic int unsigned onehot_mask(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// rtl/rr_arbiter_pick.sv - combinational round-robin pick starting just after the pointer
module rr_arbiter_pick
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan ptr+1, ptr+2, ... wrapping; the first requester found wins.
  always_comb begin : scan
    int unsigned   k;
    logic [IW-1:0] kk;
    k      = 0;
    kk     = '0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      k  = (32'(ptr) + i) % NREQ;
      kk = IW'(k);
      if (!any && req[kk]) begin
        any    = 1'b1;
        idx    = kk;
        onehot = NREQ'(onehot_mask(k));
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-level round-robin sharing of one uart byte transmitter
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = UART_DW,
  parameter int TIMEOUT = UART_TIMEOUT,
  parameter int TOW     = UART_TOW
) (
  input  logic               sysclk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*DW-1:0] data_i,
  input  logic [NREQ-1:0]    last_i,
  output logic [NREQ-1:0]    ack_o,
  output logic [NREQ-1:0]    grant_o,
  output logic               tx_start_o,
  output logic [DW-1:0]      tx_data_o,
  input  logic               tx_busy_i,
  input  logic               tx_done_i,
  output logic               err_o,
  input  logic               err_clr_i
);

  localparam int             IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TOW-1:0] TMO_LAST = TOW'(TIMEOUT - 1);
  localparam logic [IW-1:0]  PTR_RST  = IW'(NREQ - 1);

  arb_state_e      state, state_d;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic            last_q;
  logic [TOW-1:0]  cnt;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic [DW-1:0]   data_arr [NREQ];
  logic            req_g;
  logic            tmo_hit;
  logic            grab;
  logic            fire;
  logic            release_g;
  logic            tmo_set;
  logic            cnt_run;

  rr_arbiter_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req_i),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Split the packed data bus into one byte per requester.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      data_arr[k] = data_i[k*DW +: DW];
    end
  end

  assign req_g   = req_i[gidx];
  assign tmo_hit = (cnt == TMO_LAST);

  // State register; reset drops any grant immediately.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state: arbitrate once per message, then alternate LOAD/WAIT until last byte, drop or timeout.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (|req_i) state_d = ST_ARB;
      ST_ARB:  state_d = pick_any ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        if (!req_g)          state_d = ST_IDLE;
        else if (!tx_busy_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_i)    state_d = last_q ? ST_IDLE : ST_LOAD;
        else if (tmo_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control strobes decoded from the current state; done beats a coincident timeout.
  always_comb begin
    grab      = (state == ST_ARB) && pick_any;
    fire      = (state == ST_LOAD) && req_g && !tx_busy_i;
    tmo_set   = (state == ST_WAIT) && !tx_done_i && tmo_hit;
    cnt_run   = (state == ST_WAIT) && !tx_done_i && !tmo_hit;
    release_g = ((state == ST_LOAD) && !req_g)
              || ((state == ST_WAIT) && tx_done_i && last_q)
              || tmo_set;
  end

  // Grant, byte capture, start/ack pulses, timeout counter and the sticky error flag.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= PTR_RST;
      gidx       <= '0;
      grant_o    <= '0;
      ack_o      <= '0;
      tx_start_o <= 1'b0;
      tx_data_o  <= '0;
      last_q     <= 1'b0;
      cnt        <= '0;
      err_o      <= 1'b0;
    end else begin
      ack_o      <= '0;
      tx_start_o <= 1'b0;
      if (grab) begin
        grant_o <= pick_oh;
        gidx    <= pick_idx;
      end
      if (fire) begin
        tx_start_o <= 1'b1;
        ack_o      <= grant_o;
        tx_data_o  <= data_arr[gidx];
        last_q     <= last_i[gidx];
        cnt        <= '0;
      end else if (cnt_run) begin
        cnt <= cnt + TOW'(1);
      end
      if (release_g) begin
        grant_o <= '0;
        ptr     <= gidx;
      end
      if (tmo_set) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 40;
  localparam int TOW     = 6;

  logic               sysclk = 1'b0;
  logic               reset_n = 1'b0;
  logic [NREQ-1:0]    req_i = '0;
  logic [NREQ*DW-1:0] data_i = '0;
  logic [NREQ-1:0]    last_i = '0;
  logic [NREQ-1:0]    ack_o;
  logic [NREQ-1:0]    grant_o;
  logic               tx_start_o;
  logic [DW-1:0]      tx_data_o;
  logic               tx_busy_i = 1'b0;
  logic               tx_done_i = 1'b0;
  logic               err_o;
  logic               err_clr_i = 1'b0;

  always #5 sysclk = ~sysclk;

  uart_tx_arbiter #(
    .NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT), .TOW(TOW)
  ) dut (
    .sysclk     (sysclk),
    .reset_n    (reset_n),
    .req_i      (req_i),
    .data_i     (data_i),
    .last_i     (last_i),
    .ack_o      (ack_o),
    .grant_o    (grant_o),
    .tx_start_o (tx_start_o),
    .tx_data_o  (tx_data_o),
    .tx_busy_i  (tx_busy_i),
    .tx_done_i  (tx_done_i),
    .err_o      (err_o),
    .err_clr_i  (err_clr_i)
  );

  typedef struct packed {
    logic [15:0] lens;
    logic [7:0]  nbytes;
    logic [47:0] order;
  } vec_t;

  vec_t       tbl [5];
  int         checks = 0;
  int         errors = 0;
  logic [8:0] pend [NREQ][$];
  logic [8:0] cp   [NREQ][$];
  int         exp_owner[$];
  logic [7:0] exp_byte[$];
  int         got_owner[$];
  logic [7:0] got_byte[$];
  int         model_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  function automatic int oh_index(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic int pending_total();
    int n = 0;
    for (int k = 0; k < NREQ; k++) n += pend[k].size();
    return n;
  endfunction

  task automatic drive_reqs();
    logic [8:0] h;
    for (int k = 0; k < NREQ; k++) begin
      if (pend[k].size() > 0) begin
        h = pend[k][0];
        req_i[k] = 1'b1;
        data_i[k*DW +: DW] = h[7:0];
        last_i[k] = h[8];
      end else begin
        req_i[k] = 1'b0;
        data_i[k*DW +: DW] = '0;
        last_i[k] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_i = '0; data_i = '0; last_i = '0;
    tx_busy_i = 1'b0; tx_done_i = 1'b0; err_clr_i = 1'b0;
    for (int k = 0; k < NREQ; k++) pend[k].delete();
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic finish_byte(input int d);
    tx_busy_i = 1'b1;
    repeat (d - 1) tick();
    tx_done_i = 1'b1;
    tx_busy_i = 1'b0;
    tick();
    tx_done_i = 1'b0;
  endtask

  // Reference: whole messages, round-robin from the requester after the last owner.
  task automatic build_expected();
    int found;
    int k;
    logic [8:0] h;
    for (int r = 0; r < NREQ; r++) cp[r] = pend[r];
    exp_owner.delete();
    exp_byte.delete();
    while (1) begin
      found = -1;
      for (int s = 1; s <= NREQ; s++) begin
        k = (model_ptr + s) % NREQ;
        if (found < 0 && cp[k].size() > 0) found = k;
      end
      if (found < 0) break;
      do begin
        h = cp[found].pop_front();
        exp_owner.push_back(found);
        exp_byte.push_back(h[7:0]);
      end while (!h[8] && cp[found].size() > 0);
      model_ptr = found;
    end
  endtask

  task automatic run_traffic(input int budget, input int dmin, input int dmax);
    int cyc = 0;
    int left = 0;
    int bad = 0;
    int gi;
    logic [7:0] cur = '0;
    got_owner.delete();
    got_byte.delete();
    drive_reqs();
    while ((pending_total() > 0 || tx_busy_i) && cyc < budget) begin
      tick();
      cyc++;
      tx_done_i = 1'b0;
      if (tx_start_o) begin
        gi = oh_index(grant_o);
        if (ack_o !== grant_o || !$onehot(ack_o) || tx_busy_i) bad++;
        got_owner.push_back(gi);
        got_byte.push_back(tx_data_o);
        cur = tx_data_o;
        if (gi >= 0 && pend[gi].size() > 0) void'(pend[gi].pop_front());
        else bad++;
        tx_busy_i = 1'b1;
        left = $urandom_range(dmax, dmin);
      end else begin
        if (ack_o !== '0) bad++;
        if (tx_busy_i) begin
          if (tx_data_o !== cur) bad++;
          left--;
          if (left <= 0) begin
            tx_done_i = 1'b1;
            tx_busy_i = 1'b0;
          end
        end
      end
      if (!$onehot0(grant_o)) bad++;
      drive_reqs();
    end
    tick();
    tx_done_i = 1'b0;
    tick(); tick();
    check("traffic_in_budget", 32'(cyc < budget), 1);
    check("traffic_protocol", bad, 0);
    check("traffic_grant_idle", grant_o, 0);
  endtask

  task automatic compare_seq(input string tag);
    int n;
    check($sformatf("%s_nbytes", tag), got_owner.size(), exp_owner.size());
    n = (got_owner.size() < exp_owner.size()) ? got_owner.size() : exp_owner.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_owner%0d", tag, i), got_owner[i], exp_owner[i]);
      check($sformatf("%s_byte%0d", tag, i), got_byte[i], exp_byte[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int cnt_own [NREQ];
    int len;
    int o;

    // owner order nibble i = owner of byte i, after reset (requester 0 first)
    tbl[0] = '{lens: 16'h0001, nbytes: 8'd1, order: 48'h0};
    tbl[1] = '{lens: 16'h1111, nbytes: 8'd4, order: 48'h3210};
    tbl[2] = '{lens: 16'h0130, nbytes: 8'd4, order: 48'h2111};
    tbl[3] = '{lens: 16'h2002, nbytes: 8'd4, order: 48'h3300};
    tbl[4] = '{lens: 16'h1210, nbytes: 8'd4, order: 48'h3221};

    tick();
    check("rst_grant", grant_o, 0);
    check("rst_ack", ack_o, 0);
    check("rst_start", tx_start_o, 0);
    check("rst_data", tx_data_o, 0);
    check("rst_err", err_o, 0);

    // single byte, exact latency, engine done 10 cycles after start
    do_reset();
    req_i = 4'b0001; data_i[7:0] = 8'h41; last_i = 4'b0001;
    tick();
    check("a_arb_grant", grant_o, 0);
    check("a_arb_start", tx_start_o, 0);
    tick();
    check("a_load_grant", grant_o, 4'b0001);
    check("a_load_start", tx_start_o, 0);
    tick();
    check("a_start", tx_start_o, 1);
    check("a_ack", ack_o, 4'b0001);
    check("a_data", tx_data_o, 8'h41);
    req_i = '0; last_i = '0;
    got = 0;
    tx_busy_i = 1'b1;
    repeat (9) begin tick(); got += 32'(tx_start_o); end
    tx_done_i = 1'b1; tx_busy_i = 1'b0;
    tick();
    tx_done_i = 1'b0;
    got += 32'(tx_start_o);
    check("a_release", grant_o, 0);
    check("a_no_extra_start", got, 0);

    // two-byte message, grant kept between bytes
    req_i = 4'b0010; data_i[15:8] = 8'hA1; last_i = 4'b0000;
    tick(); tick(); tick();
    check("b_start1", tx_start_o, 1);
    check("b_data1", tx_data_o, 8'hA1);
    data_i[15:8] = 8'hA2; last_i = 4'b0010;
    tx_busy_i = 1'b1;
    tick();
    tx_done_i = 1'b1; tx_busy_i = 1'b0;
    tick();
    tx_done_i = 1'b0;
    check("b_grant_kept", grant_o, 4'b0010);
    got = 0;
    for (int i = 0; i < 3 && !got; i++) begin
      if (tx_start_o) got = 1;
      else tick();
    end
    check("b_start2", got, 1);
    check("b_data2", tx_data_o, 8'hA2);
    check("b_ack2", ack_o, 4'b0010);
    req_i = '0; last_i = '0;
    finish_byte(3);
    check("b_release", grant_o, 0);

    // hung engine: timeout, set beats clear, next requester served, then clear
    do_reset();
    req_i = 4'b0110; data_i[15:8] = 8'hB1; data_i[23:16] = 8'hB2; last_i = 4'b0110;
    tick(); tick(); tick();
    check("c_start", tx_start_o, 1);
    check("c_grant", grant_o, 4'b0010);
    req_i[1] = 1'b0;
    tx_busy_i = 1'b1;
    repeat (TIMEOUT - 1) tick();
    check("c_err_before", err_o, 0);
    check("c_grant_before", grant_o, 4'b0010);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("c_err_set", err_o, 1);
    check("c_grant_dropped", grant_o, 0);
    tx_busy_i = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (tx_start_o) got = 1;
    end
    check("c_next_start", got, 1);
    check("c_next_grant", grant_o, 4'b0100);
    check("c_next_data", tx_data_o, 8'hB2);
    req_i = '0; last_i = '0;
    finish_byte(2);
    check("c_err_sticky", err_o, 1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("c_err_cleared", err_o, 0);

    // done on exact timeout cycle: no error
    do_reset();
    req_i = 4'b0001; data_i[7:0] = 8'hC0; last_i = 4'b0001;
    tick(); tick(); tick();
    check("d_start", tx_start_o, 1);
    req_i = '0; last_i = '0;
    tx_busy_i = 1'b1;
    repeat (TIMEOUT - 1) tick();
    tx_done_i = 1'b1; tx_busy_i = 1'b0;
    tick();
    tx_done_i = 1'b0;
    check("d_no_err", err_o, 0);
    check("d_release", grant_o, 0);
    tick();
    check("d_no_err_later", err_o, 0);

    // requester drops req in LOAD: release with no start, pointer moves to it
    tx_busy_i = 1'b1;
    req_i = 4'b1000; data_i[31:24] = 8'hD3; last_i = 4'b1000;
    tick(); tick();
    check("e_load_grant", grant_o, 4'b1000);
    got = 32'(tx_start_o);
    req_i = '0; last_i = '0;
    tick();
    got += 32'(tx_start_o);
    check("e_drop_release", grant_o, 0);
    tx_busy_i = 1'b0;
    req_i = 4'b1001; data_i[7:0] = 8'hE0; data_i[31:24] = 8'hE3; last_i = 4'b1001;
    tick();
    got += 32'(tx_start_o);
    tick();
    got += 32'(tx_start_o);
    check("e_no_start", got, 0);
    check("e_ptr_after_drop", grant_o, 4'b0001);
    tick();
    req_i = '0; last_i = '0;
    finish_byte(2);

    // reset during WAIT, pointer returns to its reset value
    req_i = 4'b0010; data_i[15:8] = 8'hF1; last_i = 4'b0010;
    tick(); tick(); tick();
    check("f_start", tx_start_o, 1);
    req_i = '0; last_i = '0;
    tx_busy_i = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    check("f_rst_grant", grant_o, 0);
    check("f_rst_pulses", {ack_o, tx_start_o, err_o}, 0);
    check("f_rst_data", tx_data_o, 0);
    tx_busy_i = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    req_i = 4'b0101; data_i[7:0] = 8'h10; data_i[23:16] = 8'h12; last_i = 4'b0101;
    tick(); tick();
    check("f_first_after_rst", grant_o, 4'b0001);

    // table-driven message mixes
    for (int t = 0; t < 5; t++) begin
      do_reset();
      model_ptr = NREQ - 1;
      for (int k = 0; k < NREQ; k++) begin
        len = 32'(tbl[t].lens[k*4 +: 4]);
        for (int j = 0; j < len; j++) pend[k].push_back({j == len - 1, 4'(k), 4'(j)});
      end
      exp_owner.delete();
      exp_byte.delete();
      for (int k = 0; k < NREQ; k++) cnt_own[k] = 0;
      for (int i = 0; i < 32'(tbl[t].nbytes); i++) begin
        o = 32'(tbl[t].order[i*4 +: 4]);
        exp_owner.push_back(o);
        exp_byte.push_back({4'(o), 4'(cnt_own[o])});
        cnt_own[o]++;
      end
      run_traffic(2000, 1, 6);
      compare_seq($sformatf("tbl%0d", t));
    end

    // randomized rounds against the message-level reference
    do_reset();
    model_ptr = NREQ - 1;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int m = 0; m < $urandom_range(2, 0); m++) begin
          len = $urandom_range(4, 1);
          for (int j = 0; j < len; j++) pend[k].push_back({j == len - 1, 8'($urandom)});
        end
      end
      build_expected();
      run_traffic(3000, 1, 8);
      compare_seq($sformatf("rnd%0d", r));
    end
    check("final_err", err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
